// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and mem stage, one transaction in flight.
// Define ARB_RR_EN for round-robin grants when both stages request; otherwise data wins.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_by_iram,
  output logic                stall_by_dram
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                wr_q, wr_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                grant_data;
  logic                addr_ok;
  logic                data_ok;

`ifdef ARB_RR_EN
  logic last_owner_q, last_owner_d;

  // On a tie, hand the port to whoever did not have it last.
  always_comb begin
    grant_data = data_req;
    if (data_req && inst_req) grant_data = ~last_owner_q;
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == ST_IDLE && (data_req || inst_req)) last_owner_d = grant_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_owner_q <= 1'b0;
    else     last_owner_q <= last_owner_d;
  end
`else
  // The mem-stage access is older than the fetch, so it goes first.
  assign grant_data = data_req;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_req || inst_req) begin
          state_d = ST_ADDR;
          owner_d = grant_data;
          if (grant_data) begin
            wr_d    = data_wr;
            wstrb_d = data_wstrb;
            addr_d  = data_addr;
            wdata_d = data_wdata;
          end else begin
            wr_d    = 1'b0;
            wstrb_d = '0;
            addr_d  = inst_addr;
          end
        end
      end
      ST_ADDR: begin
        if (mem_addr_ok) begin
          addr_ok = 1'b1;
          if (mem_data_ok) begin
            data_ok = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (mem_data_ok) begin
          data_ok = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_req      = (state_q == ST_ADDR);
  assign mem_wr       = wr_q;
  assign mem_wstrb    = wstrb_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

  assign inst_addr_ok = addr_ok & ~owner_q;
  assign data_addr_ok = addr_ok & owner_q;
  assign inst_data_ok = data_ok & ~owner_q;
  assign data_data_ok = data_ok & owner_q;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign stall_by_iram = inst_req & ~inst_data_ok;
  assign stall_by_dram = data_req & ~data_data_ok;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (fixed priority or ARB_RR_EN).
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_by_iram, stall_by_dram;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata),
    .stall_by_iram(stall_by_iram), .stall_by_dram(stall_by_dram)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic        wr;
    logic [3:0]  st;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] rd;
    int          aw;
    int          dw;
    logic        exp_wr;
    logic [3:0]  exp_st;
  } vec_t;

  vec_t vt[6];
  int   n_pass = 0;
  int   n_tot  = 0;
  bit   model_last = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule: who gets the port from IDLE given the two requests.
  function automatic bit next_grant(input bit i, input bit d);
    if (i && d) begin
`ifdef ARB_RR_EN
      return !model_last;
`else
      return 1'b1;
`endif
    end
    return d;
  endfunction

  task automatic check_done(input bit is_d, input logic [31:0] rd);
    chk("data_ok_pair", {inst_data_ok, data_data_ok}, is_d ? 2'b01 : 2'b10);
    chk("rdata", is_d ? data_rdata : inst_rdata, rd);
    chk("owner_stall", is_d ? stall_by_dram : stall_by_iram, 1'b0);
    chk("other_stall", is_d ? stall_by_iram : stall_by_dram, is_d ? inst_req : data_req);
  endtask

  task automatic drop_req(input bit is_d);
    if (is_d) data_req = 1'b0;
    else inst_req = 1'b0;
  endtask

  task automatic serve(input bit is_d, input logic exp_wr, input logic [3:0] exp_st,
                       input logic [31:0] exp_ad, input logic [31:0] exp_wd,
                       input logic [31:0] rd, input int aw, input int dw,
                       input bit drop, input bit flush);
    int t;
    t = 0;
    tick;
    while (!mem_req && t < 20) begin
      tick;
      t++;
    end
    chk("mem_req_seen", mem_req, 1'b1);
    chk("mem_addr", mem_addr, exp_ad);
    chk("mem_wr", mem_wr, exp_wr);
    chk("mem_wstrb", mem_wstrb, exp_st);
    if (exp_wr) chk("mem_wdata", mem_wdata, exp_wd);
    model_last = is_d;
    for (int i = 0; i < aw; i++) begin
      mem_data_ok = 1'($urandom_range(0, 1));
      mem_rdata   = $urandom;
      #1;
      chk("no_ok_while_waiting", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0);
      tick;
    end
    mem_addr_ok = 1'b1;
    mem_data_ok = (dw == 0);
    mem_rdata   = rd;
    #1;
    chk("addr_ok_pair", {inst_addr_ok, data_addr_ok}, is_d ? 2'b01 : 2'b10);
    if (dw == 0) check_done(is_d, rd);
    tick;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    chk("mem_req_low_after_addr", mem_req, 1'b0);
    if (dw != 0) begin
      if (flush) drop_req(is_d);
      for (int i = 0; i < dw - 1; i++) begin
        #1;
        chk("no_data_ok_early", {inst_data_ok, data_data_ok}, 2'b0);
        tick;
      end
      mem_data_ok = 1'b1;
      mem_rdata   = rd;
      #1;
      check_done(is_d, rd);
      tick;
      mem_data_ok = 1'b0;
      chk("mem_req_idle", mem_req, 1'b0);
    end
    if (drop) drop_req(is_d);
  endtask

  task automatic issue_serve(input bit is_d, input bit drop, input int aw, input int dw,
                             input logic [31:0] rd);
    serve(is_d, is_d ? data_wr : 1'b0, is_d ? data_wstrb : 4'h0,
          is_d ? data_addr : inst_addr, data_wdata, rd, aw, dw, drop, 1'b0);
  endtask

  task automatic do_reset;
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    rst = 1'b1;
    model_last = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0);
    repeat (2) tick;
    rst = 1'b0;
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 4'h0, 32'hBFC00000, 32'h0,        32'h3C080001, 1, 1, 1'b0, 4'h0};
    vt[1] = '{1'b1, 1'b1, 4'h3, 32'h80000004, 32'h0000BEEF, 32'h0,        0, 1, 1'b1, 4'h3};
    vt[2] = '{1'b1, 1'b0, 4'hF, 32'h80000010, 32'h0,        32'h12345678, 0, 0, 1'b0, 4'hF};
    vt[3] = '{1'b0, 1'b1, 4'hF, 32'hBFC00008, 32'hDEAD0000, 32'hCAFEF00D, 0, 0, 1'b0, 4'h0};
    vt[4] = '{1'b1, 1'b0, 4'h1, 32'h80000020, 32'h0,        32'hA5A55A5A, 2, 3, 1'b0, 4'h1};
    vt[5] = '{1'b1, 1'b1, 4'hF, 32'h80000040, 32'h01020304, 32'h0,        1, 2, 1'b1, 4'hF};

    inst_addr = '0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_rdata = '0;
    do_reset;
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wr_wstrb_wdata", {mem_wr, mem_wstrb, mem_wdata}, 37'h0);

    mem_data_ok = 1'b1;
    #1;
    chk("idle_ignores_data_ok", {inst_data_ok, data_data_ok}, 2'b0);
    tick;
    mem_data_ok = 1'b0;
    chk("idle_no_req", mem_req, 1'b0);

    for (int k = 0; k < 6; k++) begin
      data_wr = vt[k].wr; data_wstrb = vt[k].st; data_addr = vt[k].ad;
      data_wdata = vt[k].wd; inst_addr = vt[k].ad;
      inst_req = !vt[k].is_d; data_req = vt[k].is_d;
      serve(vt[k].is_d, vt[k].exp_wr, vt[k].exp_st, vt[k].ad, vt[k].wd, vt[k].rd,
            vt[k].aw, vt[k].dw, 1'b1, 1'b0);
    end

    // Both requests together from IDLE.
    begin
      bit first;
      inst_addr = 32'hBFC00004; data_wr = 1'b0; data_wstrb = 4'hF; data_addr = 32'h80000010;
      inst_req = 1'b1; data_req = 1'b1;
      first = next_grant(1'b1, 1'b1);
      issue_serve(first, 1'b1, 1, 1, 32'h11112222);
      issue_serve(!first, 1'b1, 0, 1, 32'h33334444);
    end

    // Flush: requester drops mid-transaction, completion still reported.
    data_wr = 1'b0; data_wstrb = 4'hF; data_addr = 32'h80000080; data_req = 1'b1;
    serve(1'b1, 1'b0, 4'hF, 32'h80000080, 32'h0, 32'h5555AAAA, 0, 2, 1'b1, 1'b1);

    // Reset while waiting for data: the late ack must be swallowed.
    inst_addr = 32'hBFC00100; inst_req = 1'b1;
    tick;
    mem_addr_ok = 1'b1;
    #1;
    chk("rstmid_addr_ok", inst_addr_ok, 1'b1);
    tick;
    mem_addr_ok = 1'b0;
    do_reset;
    tick;
    mem_data_ok = 1'b1;
    #1;
    chk("rstmid_late_data_ok", {inst_data_ok, data_data_ok}, 2'b0);
    tick;
    mem_data_ok = 1'b0;
    chk("rstmid_mem_req", mem_req, 1'b0);

    // Both held high across four transactions.
    data_wr = 1'b0; data_wstrb = 4'hF; data_addr = 32'h80000100; inst_addr = 32'hBFC00200;
    inst_req = 1'b1; data_req = 1'b1;
    for (int k = 0; k < 4; k++) issue_serve(next_grant(1'b1, 1'b1), 1'b0, k % 2, 1, $urandom);
    do_reset;

    for (int r = 0; r < 25; r++) begin
      int mode;
      bit first;
      bit bi, bd;
      mode = $urandom_range(1, 3);
      bi = (mode != 2); bd = (mode != 1);
      inst_addr = $urandom; data_addr = $urandom; data_wdata = $urandom;
      data_wr = 1'($urandom_range(0, 1)); data_wstrb = 4'($urandom_range(0, 15));
      inst_req = bi; data_req = bd;
      first = next_grant(bi, bd);
      issue_serve(first, 1'b1, $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
      if (bi && bd) issue_serve(!first, 1'b1, $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
